// File: rtl/round_operations_if.sv
// Caller-side bundle for the SHA-256 round core: initial working variables,
// schedule fetch (index out, word in), start strobe and result.
interface round_operations_if #(
  parameter int WORD_SIZE = 32,
  parameter int IDX_W     = 6
);
  logic [WORD_SIZE-1:0] a_init, b_init, c_init, d_init;
  logic [WORD_SIZE-1:0] e_init, f_init, g_init, h_init;
  logic [WORD_SIZE-1:0] message_schedule_value;
  logic                 input_ready;

  logic [WORD_SIZE-1:0] a_final, b_final, c_final, d_final;
  logic [WORD_SIZE-1:0] e_final, f_final, g_final, h_final;
  logic [IDX_W-1:0]     message_schedule_index;
  logic                 output_ready;

  modport master (
    output a_init, b_init, c_init, d_init, e_init, f_init, g_init, h_init,
    output message_schedule_value, input_ready,
    input  a_final, b_final, c_final, d_final, e_final, f_final, g_final, h_final,
    input  message_schedule_index, output_ready
  );

  modport slave (
    input  a_init, b_init, c_init, d_init, e_init, f_init, g_init, h_init,
    input  message_schedule_value, input_ready,
    output a_final, b_final, c_final, d_final, e_final, f_final, g_final, h_final,
    output message_schedule_index, output_ready
  );
endinterface

// File: rtl/round_operations.sv
// Iterative SHA-256 compression: one round per clock over 64 rounds, schedule
// word fetched combinationally through message_schedule_index.
module round_operations #(
  parameter int WORD_SIZE = 32,
  parameter int ROUNDS    = 64
) (
  input  logic              clock,
  input  logic              clear_n,
  round_operations_if.slave bus
);
  localparam int IDX_W = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [WORD_SIZE-1:0] word_t;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_SIZE - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t k_rom(input logic [IDX_W-1:0] t);
    word_t k;
    case (t)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = '0;
    endcase
    return k;
  endfunction

  logic [1:0]       state_reg, state_next;
  logic [IDX_W-1:0] t_reg, t_next;
  logic             ready_reg, ready_next;
  word_t            wv_reg [8];
  word_t            wv_next [8];
  word_t            init_w [8];
  word_t            shift_in [8];
  word_t            t1, t2;

  // Working variables are held as a..h = wv_reg[0..7].
  assign init_w[0] = bus.a_init;
  assign init_w[1] = bus.b_init;
  assign init_w[2] = bus.c_init;
  assign init_w[3] = bus.d_init;
  assign init_w[4] = bus.e_init;
  assign init_w[5] = bus.f_init;
  assign init_w[6] = bus.g_init;
  assign init_w[7] = bus.h_init;

  assign t1 = wv_reg[7] + big_sigma1(wv_reg[4])
            + ((wv_reg[4] & wv_reg[5]) ^ (~wv_reg[4] & wv_reg[6]))
            + k_rom(t_reg) + bus.message_schedule_value;
  assign t2 = big_sigma0(wv_reg[0])
            + ((wv_reg[0] & wv_reg[1]) ^ (wv_reg[0] & wv_reg[2]) ^ (wv_reg[1] & wv_reg[2]));

  // Only a and e take new sums; every other variable shifts down one slot.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      if (gi == 0) begin : g_a
        assign shift_in[gi] = t1 + t2;
      end else if (gi == 4) begin : g_e
        assign shift_in[gi] = wv_reg[3] + t1;
      end else begin : g_pass
        assign shift_in[gi] = wv_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    ready_next = ready_reg;
    for (int i = 0; i < 8; i++) wv_next[i] = wv_reg[i];

    case (state_reg)
      ST_RUN: begin
        for (int i = 0; i < 8; i++) wv_next[i] = shift_in[i];
        t_next = t_reg + 1'b1;
        if (t_reg == LAST_ROUND) begin
          state_next = ST_DONE;
          ready_next = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new block; a strobe held through RUN is ignored there.
        if (bus.input_ready) begin
          for (int i = 0; i < 8; i++) wv_next[i] = init_w[i];
          t_next     = '0;
          ready_next = 1'b0;
          state_next = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_reg <= ST_IDLE;
      t_reg     <= '0;
      ready_reg <= 1'b0;
      for (int i = 0; i < 8; i++) wv_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      ready_reg <= ready_next;
      for (int i = 0; i < 8; i++) wv_reg[i] <= wv_next[i];
    end
  end

  assign bus.message_schedule_index = (state_reg == ST_RUN) ? t_reg : '0;
  assign bus.output_ready           = ready_reg;

  assign bus.a_final = wv_reg[0];
  assign bus.b_final = wv_reg[1];
  assign bus.c_final = wv_reg[2];
  assign bus.d_final = wv_reg[3];
  assign bus.e_final = wv_reg[4];
  assign bus.f_final = wv_reg[5];
  assign bus.g_final = wv_reg[6];
  assign bus.h_final = wv_reg[7];
endmodule

// File: tb/tb_round_operations.sv
// Directed + randomized checks of the SHA-256 round core against a plain
// arithmetic compression model and the known "abc" vectors.
module tb_round_operations;
  logic clock   = 1'b0;
  logic clear_n = 1'b0;

  round_operations_if bus ();

  round_operations #(.WORD_SIZE(32), .ROUNDS(64)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] w_arr  [64];
  logic [31:0] init_v [8];
  logic [31:0] exp_v  [8];
  logic [31:0] r0_v   [8];
  logic [31:0] cmp_v  [8];
  int cmp_cnt = 0;
  int err_cnt = 0;

  // The caller's schedule memory, read combinationally by index.
  assign bus.message_schedule_value = w_arr[bus.message_schedule_index];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Straight FIPS 180-4 compression loop on scalar variables.
  task automatic ref_compress();
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, ch, mj, t1, t2;
    a = init_v[0]; b = init_v[1]; c = init_v[2]; d = init_v[3];
    e = init_v[4]; f = init_v[5]; g = init_v[6]; h = init_v[7];
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      ch = (e & f) ^ (~e & g);
      t1 = h + s1 + ch + K_TAB[t] + w_arr[t];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      mj = (a & b) ^ (a & c) ^ (b & c);
      t2 = s0 + mj;
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
      if (t == 0) r0_v = '{a, b, c, d, e, f, g, h};
    end
    exp_v = '{a, b, c, d, e, f, g, h};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic check_vars(input string tag);
    check({tag, " a"}, bus.a_final, cmp_v[0]);
    check({tag, " b"}, bus.b_final, cmp_v[1]);
    check({tag, " c"}, bus.c_final, cmp_v[2]);
    check({tag, " d"}, bus.d_final, cmp_v[3]);
    check({tag, " e"}, bus.e_final, cmp_v[4]);
    check({tag, " f"}, bus.f_final, cmp_v[5]);
    check({tag, " g"}, bus.g_final, cmp_v[6]);
    check({tag, " h"}, bus.h_final, cmp_v[7]);
  endtask

  task automatic check_reset_state(input string tag);
    cmp_v = '{default: 32'h0};
    check_vars(tag);
    check({tag, " ready"}, 32'(bus.output_ready), 32'h0);
    check({tag, " idx"}, 32'(bus.message_schedule_index), 32'h0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_init();
    bus.a_init = init_v[0]; bus.b_init = init_v[1]; bus.c_init = init_v[2]; bus.d_init = init_v[3];
    bus.e_init = init_v[4]; bus.f_init = init_v[5]; bus.g_init = init_v[6]; bus.h_init = init_v[7];
  endtask

  task automatic scramble_init();
    bus.a_init = $urandom; bus.b_init = $urandom; bus.c_init = $urandom; bus.d_init = $urandom;
    bus.e_init = $urandom; bus.f_init = $urandom; bus.g_init = $urandom; bus.h_init = $urandom;
  endtask

  // Start a block and follow it to completion. hold = cycles input_ready stays high
  // from the start edge; busy_at = round at which an extra strobe is pulsed (-1: none).
  task automatic run_block(input string tag, input int hold, input int busy_at,
                           input bit chk_idx, input bit chk_r0);
    int n;
    drive_init();
    bus.input_ready = 1'b1;
    tick();
    n = 0;
    while (bus.output_ready !== 1'b1 && n < 80) begin
      if (chk_idx) check({tag, " idx"}, 32'(bus.message_schedule_index), 32'(n));
      bus.input_ready = ((n + 1) < hold) || (n == busy_at);
      scramble_init();
      tick();
      n++;
      if (n == 1 && chk_r0) begin
        cmp_v = r0_v;
        check_vars({tag, " round0"});
      end
    end
    bus.input_ready = 1'b0;
    check({tag, " latency"}, 32'(n), 32'd64);
    check({tag, " ready"}, 32'(bus.output_ready), 32'h1);
    cmp_v = exp_v;
    check_vars({tag, " final"});
    if (chk_idx) check({tag, " idx_done"}, 32'(bus.message_schedule_index), 32'h0);
    $display("block %s: %0d cycles, a=%08h h=%08h", tag, n, bus.a_final, bus.h_final);
  endtask

  task automatic load_abc();
    w_arr = '{default: 32'h0};
    w_arr[0]  = 32'h61626380;
    w_arr[15] = 32'h00000018;
    for (int t = 16; t < 64; t++)
      w_arr[t] = ssig1(w_arr[t-2]) + w_arr[t-7] + ssig0(w_arr[t-15]) + w_arr[t-16];
    init_v = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    r0_v   = '{32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
               32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};
    exp_v  = '{32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
               32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};
  endtask

  initial begin
    bus.input_ready = 1'b0;
    init_v = '{default: 32'h0};
    drive_init();
    w_arr = '{default: 32'h0};

    // Reset pulse
    repeat (2) tick();
    clear_n = 1'b1;
    tick();
    check_reset_state("reset");
    $display("reset: checked outputs after release");

    // "abc" block; input_ready held three cycles must start only once
    load_abc();
    run_block("abc", 3, -1, 1'b1, 1'b1);

    // DONE holds its result while input_ready stays low
    repeat (3) tick();
    check("done_hold ready", 32'(bus.output_ready), 32'h1);
    cmp_v = exp_v;
    check_vars("done_hold");
    $display("done_hold: result held for 3 cycles");

    // Strobe during RUN is ignored
    run_block("busy", 1, 10, 1'b0, 1'b0);

    // Abort at round 30, then restart
    drive_init();
    bus.input_ready = 1'b1;
    tick();
    bus.input_ready = 1'b0;
    repeat (30) tick();
    check("abort idx", 32'(bus.message_schedule_index), 32'd30);
    clear_n = 1'b0;
    #1;
    check_reset_state("abort");
    tick();
    clear_n = 1'b1;
    tick();
    $display("abort: cleared at round 30");
    run_block("after_abort", 1, -1, 1'b0, 1'b1);

    // Back-to-back start from DONE with an all-zero schedule
    w_arr = '{default: 32'h0};
    for (int i = 0; i < 8; i++) init_v[i] = $urandom;
    ref_compress();
    run_block("zero_w", 1, -1, 1'b1, 1'b1);

    // Random blocks against the model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) init_v[i] = $urandom;
      for (int t = 0; t < 64; t++) w_arr[t] = $urandom;
      ref_compress();
      repeat ($urandom_range(0, 3)) tick();
      run_block($sformatf("rand%0d", r), 1, (r == 2) ? 40 : -1, 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
